alu_decoder: RTL and testbench
==============================

Name: alu_decoder

Overview:
- ALU control decoder for the multicycle RV32I core.
- Takes the main-FSM ALU operation class, the current FSM phase and instruction fields.
- Produces registered ALU operand-source selects and a 4-bit ALU function code, plus an illegal-encoding flag.
- Sits between the core's main controller and the datapath ALU/operand muxes.

Parameters:
- None. All widths are fixed by the RV32I datapath.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous reset, active-high
- en  input  1  update enable; outputs hold while low
- ALU_op  input  2  operation class: 00 ADD, 01 branch compare, 10 funct-decoded, 11 PASSB
- phase  input  3  main-FSM phase code (source-select context)
- funct3  input  3  instruction bits [14:12]
- funct7b5  input  1  instruction bit 30
- funct7b0  input  1  instruction bit 25 (used only with the optional feature)
- opb5  input  1  instruction bit 5 (1 = R-type, 0 = I-type ALU)
- ALU_srcA  output  3  A-operand select: 0 PC, 1 OLDPC, 2 RS1, 3 ZERO; 4-7 unused
- ALU_srcB  output  3  B-operand select: 0 RS2, 1 IMM, 2 FOUR, 3 ZERO; 4-7 unused
- ALU_ctr  output  4  ALU function code
- illegal  output  1  unsupported encoding for the current ALU_op

Behaviour:
- All outputs registered; a new decode appears 1 cycle after the clk edge that samples it, and only when en=1.
- With en=0, outputs hold. reset overrides en.
- Reset values: ALU_srcA=0 (PC), ALU_srcB=2 (FOUR), ALU_ctr=0 (ADD), illegal=0.
- ALU_ctr codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
  - 11 reserved. 12-15 reserved for the optional feature.
- Phase to sources (A,B):
  - 0 FETCH: PC, FOUR
  - 1 DECODE: OLDPC, IMM
  - 2 EXEC_R: RS1, RS2
  - 3 EXEC_I/MEMADR: RS1, IMM
  - 4 BRANCH: RS1, RS2
  - 5 LINK: OLDPC, FOUR
  - 6 LUI: ZERO, IMM
  - 7 AUIPC: OLDPC, IMM
- ALU_op=00: ALU_ctr=ADD, illegal=0.
- ALU_op=01 (branch), selected by funct3:
  - 000/001 -> SUB
  - 100/101 -> SLT
  - 110/111 -> SLTU
  - 010/011 -> ADD with illegal=1
- ALU_op=10, selected by funct3:
  - 000 -> SUB when opb5=1 and funct7b5=1, else ADD (ADDI never subtracts)
  - 001 -> SLL; 010 -> SLT; 011 -> SLTU; 100 -> XOR
  - 101 -> SRA when funct7b5=1, else SRL (for both R and I types)
  - 110 -> OR; 111 -> AND
  - illegal=1 if funct7b5=1 and funct3 not in {000,101}, when opb5=1 or funct3=001.
  - illegal=1 if opb5=1 and funct7b0=1 (feature disabled).
  - When illegal, ALU_ctr is still the decoded code above.
- ALU_op=11: ALU_ctr=PASSB, illegal=0.
- Source selects depend only on phase; ALU_ctr and illegal depend only on ALU_op and the funct/opcode fields. Both are computed in the same cycle.
- Reset asserted mid-stream returns all outputs to reset values on that edge, regardless of en.

Optional Feature:
- ALU_DECODER_MEXT_EN
- Defined: when ALU_op=10, opb5=1 and funct7b0=1, decode the M-extension:
  - funct3 000 -> 12 MUL, 001 -> 13 MULH, 010 -> 14 MULHSU, 011 -> 15 MULHU, illegal=0.
  - funct3 1xx (divide) -> ALU_ctr=0 with illegal=1.
  - funct7b5=1 together with funct7b0=1 -> illegal=1.
- Undefined: funct7b0=1 on an R-type is illegal as stated in Behaviour; codes 12-15 are never produced.

Test Plan:
- Assert reset for 2 cycles with en=1 and random inputs -> ALU_srcA=0, ALU_srcB=2, ALU_ctr=0, illegal=0.
- en=1, ALU_op=10, opb5=1, funct3=000, funct7b5=1, phase=2 -> next cycle ALU_ctr=1, srcA=2, srcB=0, illegal=0. Repeat with opb5=0 -> ALU_ctr=0, illegal=0.
- ALU_op=10, funct3=101: with funct7b5=1 -> 7; with funct7b5=0 -> 6. ALU_op=10, opb5=1, funct3=110, funct7b5=1 -> ALU_ctr=8, illegal=1.
- ALU_op=01 with funct3=000,100,110,010 -> ALU_ctr 1,3,4,0; illegal only for 010. phase=4 -> srcA=2, srcB=0.
- Sweep phase 0..7 with ALU_op=00 -> (srcA,srcB) per the phase table and ALU_ctr=0. Then drop en and change inputs -> outputs unchanged.
- ALU_op=10, opb5=1, funct7b0=1, funct3=001 -> feature off: illegal=1; feature on: ALU_ctr=13, illegal=0.

Source files
------------

// File: rtl/alu_decoder.sv
// ALU control decoder for the multicycle RV32I core.
// Turns the main-FSM operation class, the FSM phase and instruction fields
// into registered operand-source selects, an ALU function code and an
// illegal-encoding flag.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous reset, active-high (overrides en)
//   en        update enable; outputs hold while low
//   ALU_op    operation class: 00 ADD, 01 branch compare, 10 funct-decoded, 11 PASSB
//   phase     main-FSM phase code (selects operand sources)
//   funct3    instruction bits [14:12]
//   funct7b5  instruction bit 30
//   funct7b0  instruction bit 25
//   opb5      instruction bit 5 (1 = R-type, 0 = I-type ALU)
//   ALU_srcA  A-operand select: 0 PC, 1 OLDPC, 2 RS1, 3 ZERO
//   ALU_srcB  B-operand select: 0 RS2, 1 IMM, 2 FOUR, 3 ZERO
//   ALU_ctr   ALU function code
//   illegal   unsupported encoding for the current ALU_op
//
// Build option: define ALU_DECODER_MEXT_EN to decode the M-extension
// multiplies (codes 12-15) on R-type encodings with funct7b0=1.
module alu_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] ALU_op,
    input  logic [2:0] phase,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       funct7b0,
    input  logic       opb5,
    output logic [2:0] ALU_srcA,
    output logic [2:0] ALU_srcB,
    output logic [3:0] ALU_ctr,
    output logic       illegal
);

    localparam int unsigned SRC_W = 3;
    localparam int unsigned CTR_W = 4;

    // Operand source encodings
    localparam logic [SRC_W-1:0] SRCA_PC    = SRC_W'(0);
    localparam logic [SRC_W-1:0] SRCA_OLDPC = SRC_W'(1);
    localparam logic [SRC_W-1:0] SRCA_RS1   = SRC_W'(2);
    localparam logic [SRC_W-1:0] SRCA_ZERO  = SRC_W'(3);
    localparam logic [SRC_W-1:0] SRCB_RS2   = SRC_W'(0);
    localparam logic [SRC_W-1:0] SRCB_IMM   = SRC_W'(1);
    localparam logic [SRC_W-1:0] SRCB_FOUR  = SRC_W'(2);

    // ALU function codes
    localparam logic [CTR_W-1:0] CTR_ADD   = CTR_W'(0);
    localparam logic [CTR_W-1:0] CTR_SUB   = CTR_W'(1);
    localparam logic [CTR_W-1:0] CTR_SLL   = CTR_W'(2);
    localparam logic [CTR_W-1:0] CTR_SLT   = CTR_W'(3);
    localparam logic [CTR_W-1:0] CTR_SLTU  = CTR_W'(4);
    localparam logic [CTR_W-1:0] CTR_XOR   = CTR_W'(5);
    localparam logic [CTR_W-1:0] CTR_SRL   = CTR_W'(6);
    localparam logic [CTR_W-1:0] CTR_SRA   = CTR_W'(7);
    localparam logic [CTR_W-1:0] CTR_OR    = CTR_W'(8);
    localparam logic [CTR_W-1:0] CTR_AND   = CTR_W'(9);
    localparam logic [CTR_W-1:0] CTR_PASSB = CTR_W'(10);

    logic [SRC_W-1:0] srca_d, srca_q;
    logic [SRC_W-1:0] srcb_d, srcb_q;
    logic [CTR_W-1:0] ctr_d,  ctr_q;
    logic             ill_d,  ill_q;

    // Operand sources from the FSM phase
    always_comb begin
        srca_d = SRCA_PC;
        srcb_d = SRCB_FOUR;
        case (phase)
            3'd0:    begin srca_d = SRCA_PC;    srcb_d = SRCB_FOUR; end
            3'd1:    begin srca_d = SRCA_OLDPC; srcb_d = SRCB_IMM;  end
            3'd2:    begin srca_d = SRCA_RS1;   srcb_d = SRCB_RS2;  end
            3'd3:    begin srca_d = SRCA_RS1;   srcb_d = SRCB_IMM;  end
            3'd4:    begin srca_d = SRCA_RS1;   srcb_d = SRCB_RS2;  end
            3'd5:    begin srca_d = SRCA_OLDPC; srcb_d = SRCB_FOUR; end
            3'd6:    begin srca_d = SRCA_ZERO;  srcb_d = SRCB_IMM;  end
            default: begin srca_d = SRCA_OLDPC; srcb_d = SRCB_IMM;  end
        endcase
    end

    // Function code and illegal flag from the operation class and funct fields
    always_comb begin
        ctr_d = CTR_ADD;
        ill_d = 1'b0;
        case (ALU_op)
            2'b00: ctr_d = CTR_ADD;
            2'b01: begin
                case (funct3)
                    3'b000, 3'b001: ctr_d = CTR_SUB;
                    3'b100, 3'b101: ctr_d = CTR_SLT;
                    3'b110, 3'b111: ctr_d = CTR_SLTU;
                    default: begin
                        ctr_d = CTR_ADD;
                        ill_d = 1'b1;
                    end
                endcase
            end
            2'b10: begin
                case (funct3)
                    3'b000:  ctr_d = (opb5 && funct7b5) ? CTR_SUB : CTR_ADD;
                    3'b001:  ctr_d = CTR_SLL;
                    3'b010:  ctr_d = CTR_SLT;
                    3'b011:  ctr_d = CTR_SLTU;
                    3'b100:  ctr_d = CTR_XOR;
                    3'b101:  ctr_d = funct7b5 ? CTR_SRA : CTR_SRL;
                    3'b110:  ctr_d = CTR_OR;
                    default: ctr_d = CTR_AND;
                endcase
                // funct7b5 is only meaningful for ADD/SUB and SRL/SRA; on I-types
                // it is an immediate bit except for the SLLI shamt encoding.
                ill_d = funct7b5 && (funct3 != 3'b000) && (funct3 != 3'b101)
                        && (opb5 || (funct3 == 3'b001));
`ifdef ALU_DECODER_MEXT_EN
                if (opb5 && funct7b0) begin
                    if (funct3[2]) begin
                        // Divide encodings decode as ADD and flag illegal
                        ctr_d = CTR_ADD;
                        ill_d = 1'b1;
                    end else begin
                        // MUL/MULH/MULHSU/MULHU map onto codes 12..15
                        ctr_d = {2'b11, funct3[1:0]};
                        ill_d = funct7b5;
                    end
                end
`else
                if (opb5 && funct7b0) begin
                    ill_d = 1'b1;
                end
`endif
            end
            default: ctr_d = CTR_PASSB;
        endcase
    end

    // Output registers: reset wins over enable
    always_ff @(posedge clk) begin
        if (reset) begin
            srca_q <= SRCA_PC;
            srcb_q <= SRCB_FOUR;
            ctr_q  <= CTR_ADD;
            ill_q  <= 1'b0;
        end else if (en) begin
            srca_q <= srca_d;
            srcb_q <= srcb_d;
            ctr_q  <= ctr_d;
            ill_q  <= ill_d;
        end
    end

    assign ALU_srcA = srca_q;
    assign ALU_srcB = srcb_q;
    assign ALU_ctr  = ctr_q;
    assign illegal  = ill_q;

endmodule

// File: tb/tb_alu_decoder.sv
// Self-checking bench for alu_decoder: a table-driven reference model checked
// on every falling edge, plus directed vectors with literal expectations.
module tb_alu_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1;
    logic [1:0] ALU_op = 2'b00;
    logic [2:0] phase = 3'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       funct7b0 = 1'b0;
    logic       opb5 = 1'b0;
    logic [2:0] ALU_srcA;
    logic [2:0] ALU_srcB;
    logic [3:0] ALU_ctr;
    logic       illegal;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_decoder dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .ALU_op   (ALU_op),
        .phase    (phase),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .funct7b0 (funct7b0),
        .opb5     (opb5),
        .ALU_srcA (ALU_srcA),
        .ALU_srcB (ALU_srcB),
        .ALU_ctr  (ALU_ctr),
        .illegal  (illegal)
    );

    // Reference tables indexed by phase / funct3
    int srca_tab   [8] = '{0, 1, 2, 2, 2, 1, 3, 1};
    int srcb_tab   [8] = '{2, 1, 0, 1, 0, 2, 1, 1};
    int branch_tab [8] = '{1, 1, 0, 0, 3, 3, 4, 4};
    int rtype_tab  [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

    // Expected function code and illegal flag from the decode rules
    task automatic model_decode(input int op, input int f3, input int f75,
                                input int f70, input int rb5,
                                output int ctr, output int ill);
        ctr = 0;
        ill = 0;
        if (op == 1) begin
            ctr = branch_tab[f3];
            ill = (f3 == 2 || f3 == 3) ? 1 : 0;
        end else if (op == 2) begin
            ctr = rtype_tab[f3];
            if (f3 == 0 && rb5 == 1 && f75 == 1) ctr = 1;
            if (f3 == 5 && f75 == 1) ctr = 7;
            if (f75 == 1 && f3 != 0 && f3 != 5 && (rb5 == 1 || f3 == 1)) ill = 1;
            if (rb5 == 1 && f70 == 1) begin
`ifdef ALU_DECODER_MEXT_EN
                if (f3 >= 4) begin
                    ctr = 0;
                    ill = 1;
                end else begin
                    ctr = 12 + f3;
                    ill = f75;
                end
`else
                ill = 1;
`endif
            end
        end else if (op == 3) begin
            ctr = 10;
        end
    endtask

    int  exp_a = 0, exp_b = 2, exp_c = 0, exp_i = 0;
    bit  chk_en = 1'b0;

    // Model state advances on the same edge the DUT samples
    always @(posedge clk) begin
        int c, il;
        if (reset) begin
            exp_a = 0; exp_b = 2; exp_c = 0; exp_i = 0;
            chk_en = 1'b1;
        end else if (en) begin
            model_decode(int'(ALU_op), int'(funct3), int'(funct7b5),
                         int'(funct7b0), int'(opb5), c, il);
            exp_a = srca_tab[phase];
            exp_b = srcb_tab[phase];
            exp_c = c;
            exp_i = il;
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model_srcA", int'(ALU_srcA), exp_a);
            cmp("model_srcB", int'(ALU_srcB), exp_b);
            cmp("model_ctr",  int'(ALU_ctr),  exp_c);
            cmp("model_ill",  int'(illegal),  exp_i);
        end
    end

    // Drive one vector on the falling edge, return just after the sampling edge
    task automatic step(input logic e, input logic [1:0] op, input logic [2:0] ph,
                        input logic [2:0] f3, input logic f75, input logic f70,
                        input logic rb5);
        @(negedge clk);
        en = e; ALU_op = op; phase = ph; funct3 = f3;
        funct7b5 = f75; funct7b0 = f70; opb5 = rb5;
        @(posedge clk);
        #1;
    endtask

    task automatic expect4(input string name, input int a, input int b,
                           input int c, input int il);
        cmp({name, "_srcA"}, int'(ALU_srcA), a);
        cmp({name, "_srcB"}, int'(ALU_srcB), b);
        cmp({name, "_ctr"},  int'(ALU_ctr),  c);
        cmp({name, "_ill"},  int'(illegal),  il);
    endtask

    initial begin
        logic [2:0] ph_r;
        // Reset for two cycles with random inputs
        reset = 1'b1;
        step(1'b1, 2'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        step(1'b1, 2'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        expect4("reset", 0, 2, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // SUB vs ADDI
        step(1'b1, 2'b10, 3'd2, 3'b000, 1'b1, 1'b0, 1'b1);
        expect4("sub", 2, 0, 1, 0);
        step(1'b1, 2'b10, 3'd3, 3'b000, 1'b1, 1'b0, 1'b0);
        expect4("addi", 2, 1, 0, 0);

        // Shifts and bad funct7
        step(1'b1, 2'b10, 3'd2, 3'b101, 1'b1, 1'b0, 1'b1);
        cmp("sra_ctr", int'(ALU_ctr), 7);
        step(1'b1, 2'b10, 3'd3, 3'b101, 1'b0, 1'b0, 1'b0);
        cmp("srl_ctr", int'(ALU_ctr), 6);
        step(1'b1, 2'b10, 3'd2, 3'b110, 1'b1, 1'b0, 1'b1);
        cmp("or_bad_ctr", int'(ALU_ctr), 8);
        cmp("or_bad_ill", int'(illegal), 1);
        step(1'b1, 2'b10, 3'd3, 3'b001, 1'b1, 1'b0, 1'b0);
        cmp("slli_bad_ill", int'(illegal), 1);
        step(1'b1, 2'b10, 3'd3, 3'b110, 1'b1, 1'b0, 1'b0);
        cmp("ori_imm_ill", int'(illegal), 0);

        // Branch compares
        step(1'b1, 2'b01, 3'd4, 3'b000, 1'b0, 1'b0, 1'b1);
        expect4("beq", 2, 0, 1, 0);
        step(1'b1, 2'b01, 3'd4, 3'b100, 1'b0, 1'b0, 1'b1);
        expect4("blt", 2, 0, 3, 0);
        step(1'b1, 2'b01, 3'd4, 3'b110, 1'b0, 1'b0, 1'b1);
        expect4("bltu", 2, 0, 4, 0);
        step(1'b1, 2'b01, 3'd4, 3'b010, 1'b0, 1'b0, 1'b1);
        expect4("bbad", 2, 0, 0, 1);

        // PASSB
        step(1'b1, 2'b11, 3'd6, 3'b111, 1'b1, 1'b1, 1'b1);
        expect4("passb", 3, 1, 10, 0);

        // Phase sweep with ADD
        for (int p = 0; p < 8; p++) begin
            step(1'b1, 2'b00, 3'(p), 3'b010, 1'b1, 1'b0, 1'b1);
            expect4($sformatf("phase%0d", p), srca_tab[p], srcb_tab[p], 0, 0);
        end
        // Hold with en low
        step(1'b0, 2'b11, 3'd2, 3'b110, 1'b1, 1'b0, 1'b1);
        expect4("hold1", 1, 1, 0, 0);
        step(1'b0, 2'b01, 3'd6, 3'b010, 1'b0, 1'b0, 1'b0);
        expect4("hold2", 1, 1, 0, 0);

        // R-type with funct7b0
        step(1'b1, 2'b10, 3'd2, 3'b001, 1'b0, 1'b1, 1'b1);
`ifdef ALU_DECODER_MEXT_EN
        expect4("mulh", 2, 0, 13, 0);
        step(1'b1, 2'b10, 3'd2, 3'b100, 1'b0, 1'b1, 1'b1);
        expect4("div", 2, 0, 0, 1);
`else
        expect4("m_off", 2, 0, 2, 1);
`endif

        // Mid-stream reset with en low
        @(negedge clk);
        reset = 1'b1;
        en = 1'b0;
        @(posedge clk);
        #1;
        expect4("midreset", 0, 2, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // Random stream, checked by the model
        for (int i = 0; i < 300; i++) begin
            ph_r = 3'($urandom);
            step(1'($urandom_range(0, 3) != 0), 2'($urandom), ph_r, 3'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom));
            if (i % 97 == 96) begin
                @(negedge clk);
                reset = 1'b1;
                @(posedge clk);
                #1;
                @(negedge clk);
                reset = 1'b0;
            end
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
